conv_mac_seq: RTL and testbench

CONV_MAC_SEQ -- requirements
Module: conv_mac_seq

---
 rtl/conv_mac_seq_pkg.sv | 22 ++
 rtl/conv_mac_seq_idx_cnt.sv | 82 ++++++++
 rtl/conv_mac_seq.sv | 172 +++++++++++++++++
 tb/tb_conv_mac_seq.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_mac_seq_pkg.sv
// Shared types and constants for the convolution MAC sequencer.
package conv_mac_seq_pkg;

    localparam int K_DEFAULT    = 3;
    localparam int DRAIN_CYCLES = 2;
    localparam int RD_LAT       = 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_BIAS  = 3'd2,
        ST_MAC   = 3'd3,
        ST_DRAIN = 3'd4,
        ST_OUT   = 3'd5
    } state_e;

    // Width of a kernel offset; stays at least one bit even for a 1x1 kernel.
    function automatic int idx_w(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/conv_mac_seq_idx_cnt.sv
// Nested kernel-column / kernel-row / channel counters plus the linear weight address.
module conv_idx_cnt
    import conv_mac_seq_pkg::*;
#(
    parameter int  K      = K_DEFAULT,
    parameter int  CIN_W  = 6,
    parameter int  ADDR_W = 10,
    localparam int KW     = idx_w(K)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              step_addr,
    input  logic              step_idx,
    input  logic [CIN_W-1:0]  cin,
    output logic [KW-1:0]     kx,
    output logic [KW-1:0]     ky,
    output logic [CIN_W-1:0]  ci,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);

    localparam logic [KW-1:0] K_MAX = KW'(K - 1);

    logic [KW-1:0]     kx_q, kx_d;
    logic [KW-1:0]     ky_q, ky_d;
    logic [CIN_W-1:0]  ci_q, ci_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        kx_d   = kx_q;
        ky_d   = ky_q;
        ci_d   = ci_q;
        addr_d = addr_q;
        if (clr) begin
            kx_d   = '0;
            ky_d   = '0;
            ci_d   = '0;
            addr_d = '0;
        end else begin
            if (step_addr) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (step_idx) begin
                if (kx_q == K_MAX) begin
                    kx_d = '0;
                    if (ky_q == K_MAX) begin
                        ky_d = '0;
                        ci_d = ci_q + CIN_W'(1);
                    end else begin
                        ky_d = ky_q + KW'(1);
                    end
                end else begin
                    kx_d = kx_q + KW'(1);
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments under an asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            kx_q   <= '0;
            ky_q   <= '0;
            ci_q   <= '0;
            addr_q <= '0;
        end else begin
            kx_q   <= kx_d;
            ky_q   <= ky_d;
            ci_q   <= ci_d;
            addr_q <= addr_d;
        end
    end

    assign kx   = kx_q;
    assign ky   = ky_q;
    assign ci   = ci_q;
    assign addr = addr_q;
    assign last = (kx_q == K_MAX) && (ky_q == K_MAX) && (ci_q == cin - CIN_W'(1));

endmodule

// File: rtl/conv_mac_seq.sv
// Sequencer for one output pixel: clear, bias read, K*K*cin weight/feature reads, drain, handshake.
module conv_mac_seq
    import conv_mac_seq_pkg::*;
#(
    parameter int  K      = K_DEFAULT,
    parameter int  CIN_W  = 6,
    parameter int  ADDR_W = 10,
    localparam int KW     = idx_w(K)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              abort,
    input  logic [CIN_W-1:0]  cfg_cin,
    output logic              busy,
    output logic              rd_en,
    output logic              rd_bias,
    output logic [ADDR_W-1:0] w_addr,
    output logic [KW-1:0]     f_kx,
    output logic [KW-1:0]     f_ky,
    output logic [CIN_W-1:0]  f_ci,
    output logic              mac_clr_n,
    output logic              mac_en,
    output logic              mac_only_add,
    input  logic [7:0]        mac_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data
);

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CIN_W-1:0]  cin_q, cin_d;
    logic [DW-1:0]     drain_q, drain_d;
    logic              busy_q, busy_d;
    logic              rd_en_q, rd_en_d;
    logic              rd_bias_q, rd_bias_d;
    logic              clr_n_q, clr_n_d;
    logic              out_valid_q, out_valid_d;
    logic [7:0]        out_data_q, out_data_d;
    logic [RD_LAT-1:0] en_pipe_q, en_pipe_d;
    logic [RD_LAT-1:0] add_pipe_q, add_pipe_d;
    logic [RD_LAT:0]   en_chain, add_chain;
    logic              capture;

    logic              cnt_clr, cnt_step_addr, cnt_step_idx, cnt_last;
    logic [KW-1:0]     cnt_kx, cnt_ky;
    logic [CIN_W-1:0]  cnt_ci;
    logic [ADDR_W-1:0] cnt_addr;

    assign en_chain  = {en_pipe_q, rd_en_q};
    assign add_chain = {add_pipe_q, rd_bias_q};

    always_comb begin
        state_d = state_q;
        cin_d   = cin_q;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && (cfg_cin != '0)) begin
                    state_d = ST_CLEAR;
                    cin_d   = cfg_cin;
                end
            end
            ST_CLEAR: state_d = ST_BIAS;
            ST_BIAS:  state_d = ST_MAC;
            ST_MAC: begin
                if (cnt_last) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = ST_OUT;
                    capture = 1'b1;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Abort overrides everything, including a start or a result capture in the same cycle.
        if (abort) begin
            state_d = ST_IDLE;
            capture = 1'b0;
        end

        drain_d = ((state_q == ST_DRAIN) && (state_d == ST_DRAIN)) ? drain_q + DW'(1) : '0;

        // Outputs are decoded from the next state so they change together with it.
        busy_d      = (state_d != ST_IDLE);
        rd_en_d     = (state_d == ST_BIAS) || (state_d == ST_MAC);
        rd_bias_d   = (state_d == ST_BIAS);
        clr_n_d     = (state_d != ST_CLEAR);
        out_valid_d = (state_d == ST_OUT);
        out_data_d  = capture ? mac_dout : out_data_q;

        en_pipe_d  = abort ? '0 : en_chain[RD_LAT-1:0];
        add_pipe_d = abort ? '0 : add_chain[RD_LAT-1:0];

        // The address leads the kernel indices by one: BIAS sits at 0 while the first read uses index 0.
        cnt_clr       = (state_d != ST_MAC);
        cnt_step_addr = (state_d == ST_MAC);
        cnt_step_idx  = (state_q == ST_MAC) && (state_d == ST_MAC);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            cin_q       <= '0;
            drain_q     <= '0;
            busy_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_bias_q   <= 1'b0;
            clr_n_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            en_pipe_q   <= '0;
            add_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            cin_q       <= cin_d;
            drain_q     <= drain_d;
            busy_q      <= busy_d;
            rd_en_q     <= rd_en_d;
            rd_bias_q   <= rd_bias_d;
            clr_n_q     <= clr_n_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            en_pipe_q   <= en_pipe_d;
            add_pipe_q  <= add_pipe_d;
        end
    end

    conv_idx_cnt #(
        .K      (K),
        .CIN_W  (CIN_W),
        .ADDR_W (ADDR_W)
    ) u_idx_cnt (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (cnt_clr),
        .step_addr (cnt_step_addr),
        .step_idx  (cnt_step_idx),
        .cin       (cin_q),
        .kx        (cnt_kx),
        .ky        (cnt_ky),
        .ci        (cnt_ci),
        .addr      (cnt_addr),
        .last      (cnt_last)
    );

    assign busy         = busy_q;
    assign rd_en        = rd_en_q;
    assign rd_bias      = rd_bias_q;
    assign w_addr       = cnt_addr;
    assign f_kx         = cnt_kx;
    assign f_ky         = cnt_ky;
    assign f_ci         = cnt_ci;
    assign mac_clr_n    = clr_n_q;
    assign mac_en       = en_pipe_q[RD_LAT-1];
    assign mac_only_add = add_pipe_q[RD_LAT-1];
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;

endmodule

// File: tb/tb_conv_mac_seq.sv
// Bench for conv_mac_seq: buffer and MAC-ReLU models around the DUT, a timeline reference model,
// a per-cycle compare process and directed/random scenarios.
module tb_conv_mac_seq;

    localparam int K      = 3;
    localparam int CIN_W  = 6;
    localparam int ADDR_W = 10;
    localparam int KW     = 2;

    logic              clk = 1'b0;
    logic              rstn;
    logic              start, abort, out_ready;
    logic [CIN_W-1:0]  cfg_cin;
    logic              busy, rd_en, rd_bias, mac_clr_n, mac_en, mac_only_add, out_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [KW-1:0]     f_kx, f_ky;
    logic [CIN_W-1:0]  f_ci;
    logic [7:0]        mac_dout, out_data;

    int n_checks = 0;
    int n_errors = 0;

    conv_mac_seq dut (
        .clk          (clk),
        .rstn         (rstn),
        .start        (start),
        .abort        (abort),
        .cfg_cin      (cfg_cin),
        .busy         (busy),
        .rd_en        (rd_en),
        .rd_bias      (rd_bias),
        .w_addr       (w_addr),
        .f_kx         (f_kx),
        .f_ky         (f_ky),
        .f_ci         (f_ci),
        .mac_clr_n    (mac_clr_n),
        .mac_en       (mac_en),
        .mac_only_add (mac_only_add),
        .mac_dout     (mac_dout),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Weight buffer (linear), feature buffer (ci, ky, kx) and bias; one-cycle read latency.
    logic [7:0] w_mem [0:1023];
    logic [7:0] f_mem [0:63][0:K-1][0:K-1];
    logic [7:0] bias_v;
    logic [7:0] rd_w = 8'd0;
    logic [7:0] rd_f = 8'd0;
    int         acc  = 0;

    always @(posedge clk) begin
        if (rd_en) begin
            rd_w <= rd_bias ? bias_v : w_mem[w_addr];
            rd_f <= f_mem[f_ci][f_ky][f_kx];
        end
    end

    // Quantised ReLU: negative -> 0, otherwise acc/64 saturated to 127.
    function automatic logic [7:0] quant(input int a);
        int q;
        if (a < 0) return 8'd0;
        q = a >>> 6;
        if (q > 127) q = 127;
        return 8'(q);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn)           acc <= 0;
        else if (!mac_clr_n) acc <= 0;
        else if (mac_en)     acc <= mac_only_add ? acc + $signed(rd_w) * 64
                                                 : acc + $signed(rd_w) * $signed(rd_f);
    end
    assign mac_dout = quant(acc);

    // Expected pixel: bias plus dot product of weight n+1 with feature (ci,ky,kx), n = kx + K*ky + K*K*ci.
    function automatic logic [7:0] ref_result(input int cin);
        int a;
        a = $signed(bias_v) * 64;
        for (int ci = 0; ci < cin; ci++)
            for (int ky = 0; ky < K; ky++)
                for (int kx = 0; kx < K; kx++)
                    a += $signed(w_mem[1 + kx + K*ky + K*K*ci]) * $signed(f_mem[ci][ky][kx]);
        return quant(a);
    endfunction

    // Timeline model: m_t counts cycles since the accepting edge (1 = clear, 2 = bias, 3..n+2 reads).
    bit         m_busy    = 1'b0;
    int         m_t       = 0;
    int         m_n       = 0;
    logic [7:0] m_out     = 8'd0;
    logic [7:0] m_res     = 8'd0;
    bit         m_mac_en  = 1'b0;
    bit         m_mac_add = 1'b0;

    function automatic bit e_rd_en();   return m_busy && m_t >= 2 && m_t <= m_n + 2; endfunction
    function automatic bit e_rd_bias(); return m_busy && m_t == 2;                   endfunction
    function automatic bit e_in_mac();  return m_busy && m_t >= 3 && m_t <= m_n + 2; endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_busy <= 1'b0; m_t <= 0; m_n <= 0; m_out <= 8'd0;
            m_mac_en <= 1'b0; m_mac_add <= 1'b0;
        end else begin
            m_mac_en  <= !abort && e_rd_en();
            m_mac_add <= !abort && e_rd_bias();
            if (abort) begin
                m_busy <= 1'b0;
            end else if (!m_busy) begin
                if (start && cfg_cin != 0) begin
                    m_busy <= 1'b1;
                    m_t    <= 1;
                    m_n    <= K * K * int'(cfg_cin);
                    m_res  <= ref_result(int'(cfg_cin));
                end
            end else if (m_t == m_n + 5) begin
                if (out_ready) m_busy <= 1'b0;
            end else begin
                if (m_t == m_n + 4) m_out <= m_res;
                m_t <= m_t + 1;
            end
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            check("busy",         busy,         m_busy);
            check("rd_en",        rd_en,        e_rd_en());
            check("rd_bias",      rd_bias,      e_rd_bias());
            check("w_addr",       w_addr,       e_in_mac() ? m_t - 2 : 0);
            check("f_kx",         f_kx,         e_in_mac() ? (m_t - 3) % K : 0);
            check("f_ky",         f_ky,         e_in_mac() ? ((m_t - 3) / K) % K : 0);
            check("f_ci",         f_ci,         e_in_mac() ? (m_t - 3) / (K * K) : 0);
            check("mac_clr_n",    mac_clr_n,    !(m_busy && m_t == 1));
            check("mac_en",       mac_en,       m_mac_en);
            check("mac_only_add", mac_only_add, m_mac_add);
            check("out_valid",    out_valid,    m_busy && m_t == m_n + 5);
            check("out_data",     out_data,     m_out);
        end
    end

    // Read-strobe monitor: bias/MAC read counts and the address where f_ci first steps 0 -> 1.
    int               n_bias_rd = 0;
    int               n_mac_rd  = 0;
    int               ci_step_addr = -1;
    logic [CIN_W-1:0] prev_ci = '0;

    always @(negedge clk) begin
        if (rstn) begin
            if (rd_en && rd_bias)  n_bias_rd <= n_bias_rd + 1;
            if (rd_en && !rd_bias) n_mac_rd  <= n_mac_rd + 1;
            if (rd_en && !rd_bias && f_ci == 1 && prev_ci == 0) ci_step_addr <= int'(w_addr);
            prev_ci <= f_ci;
        end
    end

    task automatic fill_const(input logic [7:0] w, input logic [7:0] f, input logic [7:0] b);
        for (int i = 0; i < 1024; i++) w_mem[i] = w;
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < K; y++)
                for (int x = 0; x < K; x++) f_mem[c][y][x] = f;
        bias_v = b;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 1024; i++) w_mem[i] = 8'($urandom);
        for (int c = 0; c < 64; c++)
            for (int y = 0; y < K; y++)
                for (int x = 0; x < K; x++) f_mem[c][y][x] = 8'($urandom);
        bias_v = 8'($urandom);
    endtask

    // Start a job on a falling edge, measure the cycle out_valid first rises, hold, then accept.
    task automatic run_job(input int cin, input int hold, input bit poke,
                           output int lat, output logic [7:0] data);
        cfg_cin = CIN_W'(cin);
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        cfg_cin = CIN_W'($urandom_range(0, 63));
        lat = 1;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(negedge clk);
            lat++;
        end
        check("out_valid_seen", out_valid, 1);
        data = out_data;
        for (int h = 0; h < hold; h++) begin
            if (poke) begin
                start   = 1'b1;
                cfg_cin = CIN_W'($urandom_range(1, 63));
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("out_hold_valid", out_valid, 1);
        check("out_hold_data", out_data, data);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("idle_after_ready", busy, 0);
    endtask

    task automatic run_abort(input int cin, input int at, input bit with_start);
        cfg_cin = CIN_W'(cin);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (at) @(negedge clk);
        abort   = 1'b1;
        start   = with_start;
        cfg_cin = CIN_W'($urandom_range(1, 63));
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_mac_en", mac_en, 0);
        check("abort_out_valid", out_valid, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat, seen, base_bias, base_mac;
        logic [7:0] data, prev_data;

        rstn = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; cfg_cin = '0;
        fill_const(8'h00, 8'h00, 8'h00);
        #3;
        check("rst_busy",      busy,      0);
        check("rst_rd_en",     rd_en,     0);
        check("rst_mac_clr_n", mac_clr_n, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_w_addr",    w_addr,    0);
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        check("clr_n_after_reset", mac_clr_n, 1);

        // Saturating case: 9 * 64 * 64 + bias easily exceeds the 8-bit range.
        fill_const(8'h40, 8'h40, 8'h10);
        run_job(1, 0, 1'b0, lat, data);
        check("sat_latency", lat, 14);
        check("sat_result", data, 8'h7F);

        // Negative bias with zero features -> ReLU clamps to 0.
        fill_const(8'h40, 8'h00, 8'h80);
        run_job(1, 1, 1'b0, lat, data);
        check("relu_latency", lat, 14);
        check("relu_result", data, 8'h00);

        // Two channels: read counts, channel-step address and latency.
        fill_random();
        base_bias = n_bias_rd;
        base_mac  = n_mac_rd;
        run_job(2, 0, 1'b0, lat, data);
        check("cin2_latency", lat, 23);
        check("cin2_bias_reads", n_bias_rd - base_bias, 1);
        check("cin2_mac_reads", n_mac_rd - base_mac, 18);
        check("cin2_ci_step_addr", ci_step_addr, 10);

        // Back-pressure with start pulses while the result waits.
        fill_random();
        run_job(1, 5, 1'b1, lat, data);
        check("hold_latency", lat, 14);

        // Abort mid-MAC at address 4, then a clean run.
        cfg_cin = CIN_W'(1);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && w_addr != 4; i++) @(negedge clk);
        check("abort_at_waddr", w_addr, 4);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("mid_abort_busy", busy, 0);
        check("mid_abort_rd_en", rd_en, 0);
        check("mid_abort_mac_en", mac_en, 0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_valid_after_abort", seen, 0);
        run_job(1, 0, 1'b0, lat, data);
        check("post_abort_latency", lat, 14);

        // Abort and start together in IDLE: abort wins.
        cfg_cin = CIN_W'(3);
        start   = 1'b1;
        abort   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("abort_beats_start", busy, 0);

        // Asynchronous reset mid-MAC.
        prev_data = out_data;
        cfg_cin = CIN_W'(2);
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_rd_en", rd_en, 0);
        check("arst_w_addr", w_addr, 0);
        check("arst_f_ci", f_ci, 0);
        check("arst_mac_en", mac_en, 0);
        check("arst_mac_clr_n", mac_clr_n, 0);
        check("arst_out_data", out_data, 0);
        @(negedge clk);
        #2 rstn = 1'b1;
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("no_valid_after_reset", seen, 0);

        // Zero channel count is ignored.
        cfg_cin = '0;
        start   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("zero_cin_idle", busy, 0);
        repeat (3) @(negedge clk);
        check("zero_cin_still_idle", busy, 0);

        // Randomised jobs and aborts in every state.
        for (int it = 0; it < 24; it++) begin
            int cin;
            fill_random();
            cin = $urandom_range(1, 4);
            if ($urandom_range(0, 3) == 0)
                run_abort(cin, $urandom_range(0, K * K * cin + 8), 1'($urandom_range(0, 1)));
            else
                run_job(cin, $urandom_range(0, 3), 1'($urandom_range(0, 1)), lat, data);
        end
        check("final_prev_data_kept", prev_data !== 8'hxx, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
